mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: max cycles in WAIT_RESP before timeout; legal range 1..255.
REQ-002 clk  in  1  clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 i_valid  in  1  fetch request valid; i_ready  out  1  fetch request accepted; i_addr  in  32  fetch address.
REQ-005 d_valid  in  1  data request valid; d_ready  out  1  data request accepted; d_addr  in  32  data address; d_wdata  in  32  store data; d_write  in  1  1=store; d_width  in  2  0=byte,1=half,2=word.
REQ-006 rdata  out  32  response data; i_rvalid  out  1  fetch response pulse; d_rvalid  out  1  data response pulse; err  out  1  timeout pulse, coincident with the *_rvalid pulse.
REQ-007 m_valid  out  1; m_ready  in  1; m_addr  out  32; m_wdata  out  32; m_write  out  1; m_width  out  2; m_rvalid  in  1; m_rdata  in  32.  Single-port memory side.

Function
REQ-008 One transaction outstanding at a time; the memory port is shared by the fetch (i_*) and data (d_*) requesters.
REQ-009 FSM states: IDLE, ISSUE, WAIT_RESP.
REQ-010 IDLE: i_ready/d_ready high only for the granted requester, combinationally from the valids; accept = valid & ready.
REQ-011 Both valid in IDLE: d wins (priority per REQ-023).
REQ-012 Accept at edge N: addr/wdata/write/width/owner registered; state goes to ISSUE; m_valid high from cycle N+1.
REQ-013 ISSUE: m_* held stable while m_ready=0; m_valid & m_ready -> WAIT_RESP, m_valid low the next cycle.
REQ-014 Fetch requests force m_write=0 and m_width=2.
REQ-015 Stores also complete via m_rvalid; there are no posted writes.
REQ-016 WAIT_RESP: m_rvalid=1 -> rdata<=m_rdata; owner's *_rvalid pulses 1 cycle on the next cycle; state -> IDLE.
REQ-017 A new accept is possible on the same edge as the response pulse; best case is one transaction per 3 cycles.
REQ-018 Wait counter: clears on entry to WAIT_RESP, increments each cycle without m_rvalid, saturates at 255.
REQ-019 Counter == WAIT_LIMIT without m_rvalid -> owner *_rvalid and err pulse, rdata=32'hFFFFFFFF, state -> IDLE.
REQ-020 m_rvalid outside WAIT_RESP is ignored; a stale response after a timeout is dropped.
REQ-021 m_rvalid on the same cycle the counter reaches the limit: the response wins and err stays 0.
REQ-022 Requester valid deasserted before accept is legal and drops that request; after accept, a drop has no effect.

Reset
REQ-023 rst=1: state IDLE, counter 0, all outputs 0 (m_valid, i_rvalid, d_rvalid, err, i_ready, d_ready, rdata, m_addr, m_wdata, m_write, m_width); round-robin pointer favours d.
REQ-024 rst mid-transaction abandons it with no response pulse; m_valid drops asynchronously.

Configuration
REQ-025 Macro MEM_ARB_RR_EN, defined: 2-way round-robin. The last-granted requester loses the next tie; the pointer updates on accept only.
REQ-026 MEM_ARB_RR_EN undefined: fixed priority, d over i; no pointer register.

Structure
REQ-027 Shared package holds: FSM state typedef, width encodings (0/1/2, matching load/store funct3[1:0]), ERR_DATA=32'hFFFFFFFF, owner enum (OWN_I, OWN_D).
REQ-028 One sub-module, rr_arbiter2: 2-input grant logic with optional pointer, instantiated once; the FSM, counter and capture registers stay top-level.

Verification
REQ-029 d_valid=1, d_addr=0x100, d_write=1, d_wdata=0xDEADBEEF, d_width=2; m_ready=1; m_rvalid 1 cycle later -> m_* shows 0x100/0xDEADBEEF/write=1 at N+1; d_rvalid at N+3; i_rvalid=0.
REQ-030 i_valid and d_valid both held high, 4 transactions -> fixed build: all d; RR build: grant order d,i,d,i.
REQ-031 m_ready held 0 for 5 cycles in ISSUE -> m_addr/m_wdata stable, no accept on i/d, then normal completion.
REQ-032 WAIT_LIMIT=3, no m_rvalid -> after 3 cycles in WAIT_RESP: i_rvalid=1, err=1, rdata=0xFFFFFFFF; late m_rvalid ignored.
REQ-033 rst pulse while in WAIT_RESP -> IDLE, no rvalid pulse; next i request at addr 0x0 completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and constants for the fetch/data memory-port arbiter.
//   - state_t   : arbiter FSM states
//   - owner_t   : which requester owns the outstanding transaction
//   - WIDTH_*   : access width codes, same encoding as load/store funct3[1:0]
//   - ERR_DATA  : read data returned on a response timeout
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RESP
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [1:0]  WIDTH_BYTE   = 2'd0;
    localparam logic [1:0]  WIDTH_HALF   = 2'd1;
    localparam logic [1:0]  WIDTH_WORD   = 2'd2;

    localparam logic [31:0] ERR_DATA     = 32'hFFFF_FFFF;
    localparam logic [7:0]  WAIT_CNT_MAX = 8'd255;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-input grant logic for the fetch (i) and data (d) requesters.
//   Build option MEM_ARB_RR_EN:
//     defined   - 2-way round robin; the requester granted last loses the
//                 next tie. The pointer moves only when upd (accept) is high
//                 and resets to favour d.
//     undefined - fixed priority, d over i; clk/rst/upd ports do not exist.
//   Ports:
//     clk, rst      clock / async active-high reset (round-robin build only)
//     upd           a grant was accepted this cycle (round-robin build only)
//     req_i, req_d  request valids
//     gnt_i, gnt_d  one-hot grant (both low when nothing requests)
module rr_arbiter2 (
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic upd,
`endif
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    // prio_d high: d wins a tie
    logic prio_d;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_d <= 1'b1;
        end else if (upd) begin
            // Whoever was just granted gives up priority for the next tie
            prio_d <= gnt_i;
        end
    end
`else
    assign prio_d = 1'b1;
`endif

    assign gnt_d = req_d & (prio_d | ~req_i);
    assign gnt_i = req_i & ~gnt_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory interface between a fetch requester (i_*)
//   and a data requester (d_*), one transaction outstanding at a time.
//   Build option MEM_ARB_RR_EN selects round-robin arbitration instead of
//   fixed d-over-i priority (see rr_arbiter2).
//   Parameter:
//     WAIT_LIMIT  cycles the wait counter may reach in WAIT_RESP before the
//                 transaction is completed with err (1..255)
//   Ports:
//     clk, rst                      clock, async active-high reset
//     i_valid/i_ready/i_addr        fetch request (always a word read)
//     d_valid/d_ready/d_addr/d_wdata/d_write/d_width   data request
//     rdata, i_rvalid, d_rvalid, err                   response to requester
//     m_valid/m_ready/m_addr/m_wdata/m_write/m_width   memory request
//     m_rvalid/m_rdata                                 memory response
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_write,
    input  logic [1:0]  d_width,
    output logic [31:0] rdata,
    output logic        i_rvalid,
    output logic        d_rvalid,
    output logic        err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_write,
    output logic [1:0]  m_width,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    state_t     state;
    state_t     state_nx;
    owner_t     owner;
    logic [7:0] wait_cnt;
    logic       gnt_i;
    logic       gnt_d;
    logic       in_idle;
    logic       i_acc;
    logic       d_acc;
    logic       accept;
    logic       timeout;

    rr_arbiter2 u_arb (
`ifdef MEM_ARB_RR_EN
        .clk   (clk),
        .rst   (rst),
        .upd   (accept),
`endif
        .req_i (i_valid),
        .req_d (d_valid),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    // Readies are gated by rst so they read 0 while reset is held
    assign in_idle = (state == ST_IDLE) && !rst;
    assign i_ready = in_idle & gnt_i;
    assign d_ready = in_idle & gnt_d;
    assign i_acc   = i_valid & i_ready;
    assign d_acc   = d_valid & d_ready;
    assign accept  = i_acc | d_acc;

    // Decoded from the state register so reset drops it asynchronously
    assign m_valid = (state == ST_ISSUE);

    // A response arriving in the limit cycle takes precedence over timeout
    assign timeout = (state == ST_WAIT_RESP) && !m_rvalid
                     && (wait_cnt == 8'(WAIT_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:      if (accept) state_nx = ST_ISSUE;
            ST_ISSUE:     if (m_ready) state_nx = ST_WAIT_RESP;
            ST_WAIT_RESP: if (m_rvalid || timeout) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= OWN_I;
            wait_cnt <= 8'd0;
            m_addr   <= 32'd0;
            m_wdata  <= 32'd0;
            m_write  <= 1'b0;
            m_width  <= WIDTH_BYTE;
            rdata    <= 32'd0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            err      <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (d_acc) begin
                        owner   <= OWN_D;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_write <= d_write;
                        m_width <= d_width;
                    end else if (i_acc) begin
                        // Fetches are word reads; store data is zeroed
                        owner   <= OWN_I;
                        m_addr  <= i_addr;
                        m_wdata <= 32'd0;
                        m_write <= 1'b0;
                        m_width <= WIDTH_WORD;
                    end
                end
                ST_ISSUE: begin
                    if (m_ready) wait_cnt <= 8'd0;
                end
                ST_WAIT_RESP: begin
                    if (m_rvalid || timeout) begin
                        rdata    <= m_rvalid ? m_rdata : ERR_DATA;
                        err      <= !m_rvalid;
                        i_rvalid <= (owner == OWN_I);
                        d_rvalid <= (owner == OWN_D);
                    end else if (wait_cnt != WAIT_CNT_MAX) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a transaction-level reference
//   model (cycle stamps for accept/handshake/response) checked every cycle,
//   plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;

    localparam int WL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, d_valid, d_ready, d_write;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_width;
    logic [31:0] rdata;
    logic        i_rvalid, d_rvalid, err;
    logic        m_valid, m_ready, m_write, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_width;

    int n_chk  = 0;
    int n_fail = 0;

    bit mem_auto  = 1'b0;
    bit auto_drop = 1'b1;
    int grants[$];

    mem_port_arbiter #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_write(d_write), .d_width(d_width),
        .rdata(rdata), .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .err(err),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_write(m_write), .m_width(m_width),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    int          hs_cyc = 0;
    bit          mb_busy = 1'b0;
    bit          m_hs = 1'b0;
    bit          own_d = 1'b0;
    bit          d_first = 1'b1;
    bit          p_i = 1'b0, p_d = 1'b0, p_e = 1'b0;
    logic [31:0] mx_addr = '0, mx_wdata = '0, mx_rdata = '0;
    logic        mx_write = 1'b0;
    logic [1:0]  mx_width = '0;

    always @(negedge clk) begin
        bit e_ir, e_dr;
        int waited;
        cyc++;
        if (rst) begin
            mb_busy = 0; m_hs = 0; own_d = 0; d_first = 1;
            p_i = 0; p_d = 0; p_e = 0;
            mx_addr = '0; mx_wdata = '0; mx_rdata = '0;
            mx_write = 0; mx_width = '0;
        end
        e_dr = !rst && !mb_busy && d_valid && (d_first || !i_valid);
        e_ir = !rst && !mb_busy && i_valid && !e_dr;
        chk("ctrl", 32'({m_valid, i_ready, d_ready, i_rvalid, d_rvalid, err, m_write, m_width}),
                    32'({mb_busy && !m_hs, e_ir, e_dr, p_i, p_d, p_e, mx_write, mx_width}));
        chk("m_addr", m_addr, mx_addr);
        chk("m_wdata", m_wdata, mx_wdata);
        chk("rdata", rdata, mx_rdata);
        if (!rst) begin
            p_i = 0; p_d = 0; p_e = 0;
            if (e_ir || e_dr) begin
                mb_busy  = 1; m_hs = 0; own_d = e_dr;
                mx_addr  = e_dr ? d_addr  : i_addr;
                mx_wdata = e_dr ? d_wdata : 32'h0;
                mx_write = e_dr ? d_write : 1'b0;
                mx_width = e_dr ? d_width : 2'd2;
`ifdef MEM_ARB_RR_EN
                d_first  = !e_dr;
`endif
            end else if (mb_busy && !m_hs) begin
                if (m_ready) begin
                    m_hs = 1; hs_cyc = cyc;
                end
            end else if (mb_busy) begin
                waited = cyc - hs_cyc - 1;
                if (m_rvalid || waited == WL) begin
                    mb_busy  = 0;
                    mx_rdata = m_rvalid ? m_rdata : 32'hFFFF_FFFF;
                    p_e = !m_rvalid;
                    p_d = own_d;
                    p_i = !own_d;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        logic        hs_s, ig, dg;
        logic [31:0] a_s;
        @(negedge clk);
        hs_s = m_valid && m_ready;
        a_s  = m_addr;
        ig   = i_valid && i_ready;
        dg   = d_valid && d_ready;
        if (ig) grants.push_back(0);
        if (dg) grants.push_back(1);
        @(posedge clk);
        #1;
        if (auto_drop) begin
            if (ig) i_valid = 1'b0;
            if (dg) d_valid = 1'b0;
        end
        if (mem_auto) begin
            m_rvalid = hs_s;
            m_rdata  = a_s ^ 32'hA5A5_A5A5;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int guard;
        int exp_g[4];
        rst = 1'b1;
        i_valid = 0; d_valid = 0; d_write = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_width = '0;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;

        // Reset: everything low, readies held off even with valids present
        tick(); tick();
        i_valid = 1; d_valid = 1;
        #1;
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        i_valid = 0; d_valid = 0;
        rst = 0;
        tick();

        // Both requesters held high: grant order over 4 transactions
        mem_auto = 1; auto_drop = 0; m_ready = 1;
        grants.delete();
        i_valid = 1; i_addr = 32'h200;
        d_valid = 1; d_addr = 32'h300; d_write = 0; d_width = 2'd1;
        guard = 0;
        while (grants.size() < 4 && guard < 40) begin
            tick();
            guard++;
        end
        i_valid = 0; d_valid = 0;
        auto_drop = 1;
        repeat (4) tick();
`ifdef MEM_ARB_RR_EN
        exp_g = '{1, 0, 1, 0};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        chk("grant_count", 32'(grants.size()), 32'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            chk($sformatf("grant_%0d", k), 32'(grants[k]), 32'(exp_g[k]));

        // Single store: m_* at N+1, d_rvalid at N+3
        d_valid = 1; d_addr = 32'h100; d_write = 1; d_wdata = 32'hDEAD_BEEF; d_width = 2'd2;
        #1;
        chk("st_d_ready", 32'(d_ready), 32'd1);
        tick();
        chk("st_m_valid", 32'(m_valid), 32'd1);
        chk("st_m_addr", m_addr, 32'h100);
        chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("st_m_write", 32'(m_write), 32'd1);
        chk("st_m_width", 32'(m_width), 32'd2);
        tick();
        chk("st_m_valid_low", 32'(m_valid), 32'd0);
        chk("st_d_rvalid_early", 32'(d_rvalid), 32'd0);
        tick();
        chk("st_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("st_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("st_rdata", rdata, 32'hA5A5_A4A5);
        tick();
        chk("st_d_rvalid_1cyc", 32'(d_rvalid), 32'd0);
        d_write = 0;

        // Issue stall: m_ready low 5 cycles, request held, no new accept
        mem_auto = 0; m_ready = 0;
        i_valid = 1; i_addr = 32'h40;
        tick();
        d_valid = 1; d_addr = 32'h500; d_write = 1; d_wdata = 32'h11; d_width = 2'd0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("stall_m_valid", 32'(m_valid), 32'd1);
            chk("stall_m_addr", m_addr, 32'h40);
            chk("stall_fetch_attr", 32'({m_write, m_width}), 32'd2);
            chk("stall_d_ready", 32'(d_ready), 32'd0);
            tick();
        end
        d_valid = 0; d_write = 0; m_ready = 1;
        tick();
        m_ready = 0; m_rvalid = 1; m_rdata = 32'h0BAD_F00D;
        tick();
        m_rvalid = 0;
        chk("stall_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("stall_rdata", rdata, 32'h0BAD_F00D);
        chk("stall_err", 32'(err), 32'd0);

        // Timeout with WAIT_LIMIT=3, then a late response is dropped
        m_ready = 1;
        i_valid = 1; i_addr = 32'h600;
        tick();
        repeat (4) tick();
        chk("to_not_yet", 32'({i_rvalid, err}), 32'd0);
        tick();
        chk("to_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_rdata", rdata, 32'hFFFF_FFFF);
        m_rvalid = 1; m_rdata = 32'h1234_5678;
        tick();
        m_rvalid = 0;
        chk("late_pulses", 32'({i_rvalid, d_rvalid, err, m_valid}), 32'd0);
        chk("late_rdata", rdata, 32'hFFFF_FFFF);

        // Response in the same cycle the counter hits the limit wins
        i_valid = 1; i_addr = 32'h700;
        tick();
        repeat (4) tick();
        m_rvalid = 1; m_rdata = 32'h77;
        tick();
        m_rvalid = 0;
        chk("edge_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("edge_err", 32'(err), 32'd0);
        chk("edge_rdata", rdata, 32'h77);

        // Reset while waiting for a response: no pulse, then normal fetch
        i_valid = 1; i_addr = 32'h800;
        tick(); tick(); tick();
        rst = 1;
        #1;
        chk("rstw_pulses", 32'({i_rvalid, d_rvalid, err, m_valid}), 32'd0);
        tick(); tick();
        rst = 0;
        chk("rstw_after", 32'({i_rvalid, d_rvalid, err}), 32'd0);
        tick();
        mem_auto = 1;
        i_valid = 1; i_addr = 32'h0;
        tick(); tick(); tick();
        chk("rstw_next_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("rstw_next_rdata", rdata, 32'hA5A5_A5A5);
        chk("rstw_next_err", 32'(err), 32'd0);

        // Reset in ISSUE drops m_valid without waiting for a clock
        mem_auto = 0; m_ready = 0;
        i_valid = 1; i_addr = 32'h900;
        tick();
        #1;
        chk("rsti_m_valid_before", 32'(m_valid), 32'd1);
        rst = 1;
        #1;
        chk("rsti_m_valid_async", 32'(m_valid), 32'd0);
        tick();
        rst = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
